pipe_interlock_ctrl: RTL

//  Hazard/interlock controller and consumer-side steering for the OF/EX pipeline register.

---
 rtl/pipe_interlock_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_interlock_ctrl.sv
// pipe_interlock_ctrl
// Hazard/interlock controller for the OF/EX pipeline register. It resolves
// load-use stalls, taken-branch flushes and multicycle mul/div occupancy of
// EX, and keeps saturating stall/flush performance counters.
// Control outputs are combinational from state, md_cnt and the inputs, so
// they act in the same cycle that a hazard is seen.

module pipe_interlock_ctrl #(
  parameter int MD_LATENCY = 4,   // EX cycles per mul/div/mod op, 2..16
  parameter int CNT_W      = 32   // performance counter width
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             of_valid,
  input  logic [3:0]       of_rs1,
  input  logic             of_rs1_used,
  input  logic [3:0]       of_rs2,
  input  logic             of_rs2_used,
  input  logic             ex_valid,
  input  logic             ex_is_ld,
  input  logic             ex_wb_en,
  input  logic [3:0]       ex_rd,
  input  logic             ex_is_md,
  input  logic             ex_branch_taken,
  input  logic             cnt_clr,
  output logic             stall_pc,
  output logic             stall_if_of,
  output logic             bubble_of_ex,
  output logic             hold_of_ex,
  output logic             bubble_ex_ma,
  output logic             flush_if_of,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // The start cycle in IDLE is EX cycle 0, so BUSY counts down from
  // MD_LATENCY-2 and the md_cnt==0 cycle is the final one.
  localparam logic [3:0] MD_INIT = 4'(MD_LATENCY - 2);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [3:0]       md_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  logic rs1_hit_s;
  logic rs2_hit_s;
  logic branch_s;
  logic md_start_s;
  logic load_use_s;

  logic stall_pc_s;
  logic stall_if_of_s;
  logic bubble_of_ex_s;
  logic hold_of_ex_s;
  logic bubble_ex_ma_s;
  logic flush_if_of_s;
  logic md_busy_s;
  logic md_done_s;

  // Hazard detection terms; ex_valid gates every EX-side hazard.
  always_comb begin
    rs1_hit_s  = of_rs1_used & (of_rs1 == ex_rd);
    rs2_hit_s  = of_rs2_used & (of_rs2 == ex_rd);
    branch_s   = ex_valid & ex_branch_taken;
    md_start_s = ex_valid & ex_is_md;
    load_use_s = ex_valid & ex_is_ld & ex_wb_en & of_valid & (rs1_hit_s | rs2_hit_s);
  end

  // Pipeline controls by state and priority; everything low while in reset.
  always_comb begin
    stall_pc_s     = 1'b0;
    stall_if_of_s  = 1'b0;
    bubble_of_ex_s = 1'b0;
    hold_of_ex_s   = 1'b0;
    bubble_ex_ma_s = 1'b0;
    flush_if_of_s  = 1'b0;
    md_busy_s      = 1'b0;
    md_done_s      = 1'b0;
    if (reset) begin
      md_busy_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (branch_s) begin
            flush_if_of_s  = 1'b1;
            bubble_of_ex_s = 1'b1;
          end else if (md_start_s) begin
            stall_pc_s     = 1'b1;
            stall_if_of_s  = 1'b1;
            hold_of_ex_s   = 1'b1;
            bubble_ex_ma_s = 1'b1;
          end else if (load_use_s) begin
            stall_pc_s     = 1'b1;
            stall_if_of_s  = 1'b1;
            bubble_of_ex_s = 1'b1;
          end else begin
            stall_pc_s = 1'b0;
          end
        end
        BUSY: begin
          md_busy_s = 1'b1;
          if (md_cnt_r != 4'd0) begin
            stall_pc_s     = 1'b1;
            stall_if_of_s  = 1'b1;
            hold_of_ex_s   = 1'b1;
            bubble_ex_ma_s = 1'b1;
          end else begin
            md_done_s = 1'b1;
          end
        end
        default: begin
          md_busy_s = 1'b0;
        end
      endcase
    end
  end

  // Mul/div occupancy sequencer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      md_cnt_r <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!branch_s && md_start_s) begin
            md_cnt_r <= MD_INIT;
            state_r  <= BUSY;
          end
        end
        BUSY: begin
          if (md_cnt_r != 4'd0) begin
            md_cnt_r <= md_cnt_r - 4'd1;
          end else begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r  <= IDLE;
          md_cnt_r <= 4'd0;
        end
      endcase
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_pc_s && !(&stall_cnt_r)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (flush_if_of_s && !(&flush_cnt_r)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
    end
  end

  assign stall_pc     = stall_pc_s;
  assign stall_if_of  = stall_if_of_s;
  assign bubble_of_ex = bubble_of_ex_s;
  assign hold_of_ex   = hold_of_ex_s;
  assign bubble_ex_ma = bubble_ex_ma_s;
  assign flush_if_of  = flush_if_of_s;
  assign md_busy      = md_busy_s;
  assign md_done      = md_done_s;
  assign stall_cycles = stall_cnt_r;
  assign flush_count  = flush_cnt_r;

endmodule
